// File: rtl/pc_gen_multi.sv
// pc_gen_multi
//   Fetch PC generator for a multi-issue front end. Holds the fetch-group PC,
//   advances it by the number of slots the fetch queue consumed, and reports
//   a per-slot valid mask that never crosses an aligned fetch-group boundary.
//   Exception/branch redirects are applied when the front end can move, or
//   parked in a single pending entry while it is frozen.
//
// Ports
//   clk            clock
//   resetn         synchronous, active-low reset
//   en_i           front-end enable (0 = hold PC)
//   stall_i        cache-side stall (1 = hold PC)
//   queue_full_i   fetch queue full; PC holds, redirects still apply
//   accept_cnt_i   slots of the current group consumed this cycle
//   exc_valid_i    exception redirect request, target exc_addr_i
//   br_valid_i     branch/jump redirect request, target br_addr_i
//   pc_o           current fetch-group PC (slot 0 address)
//   slot_valid_o   slot i (address pc_o + 4*i) holds a valid fetch
//   fetch_req_o    fetch request to the I-cache
//   redirect_o     one-cycle pulse: pc_o was just loaded from a redirect
//   pc_adel_o      pc_o is misaligned (fetch address error)
//   state_o        FSM state (BOOT=0, RUN=1, HOLD=2)
//
// Handshake: fetch_req_o/slot_valid_o describe the group at pc_o this cycle;
// the consumer returns accept_cnt_i in the same cycle and the PC advances at
// the next edge. A count larger than the valid slot count is clamped so no
// unfetched slot is ever skipped.
module pc_gen_multi #(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_VEC   = 32'hBFC0_0000,
  localparam int         CW          = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en_i,
  input  logic                   stall_i,
  input  logic                   queue_full_i,
  input  logic [CW-1:0]          accept_cnt_i,
  input  logic                   exc_valid_i,
  input  logic [31:0]            exc_addr_i,
  input  logic                   br_valid_i,
  input  logic [31:0]            br_addr_i,
  output logic [31:0]            pc_o,
  output logic [FETCH_WIDTH-1:0] slot_valid_o,
  output logic                   fetch_req_o,
  output logic                   redirect_o,
  output logic                   pc_adel_o,
  output logic [1:0]             state_o
);

  localparam int OFFW = $clog2(FETCH_WIDTH);
  localparam int OW   = (OFFW > 0) ? OFFW : 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_is_exc_q, pend_is_exc_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic                   go;
  logic                   fetch_req;
  logic                   pc_adel;
  logic [OW-1:0]          grp_off;
  logic [31:0]            off_ext;
  logic [FETCH_WIDTH-1:0] slot_vld;
  logic [CW-1:0]          pop;
  logic [CW-1:0]          adv;

  // Slot position of pc within its aligned fetch group.
  generate
    if (FETCH_WIDTH == 1) begin : g_off_single
      assign grp_off = '0;
    end else begin : g_off_multi
      assign grp_off = pc_q[OFFW+1:2];
    end
  endgenerate

  assign off_ext   = 32'(grp_off);
  assign fetch_req = (state_q != BOOT);
  assign pc_adel   = (pc_q[1:0] != 2'b00);
  assign go        = en_i & ~stall_i & (state_q != BOOT);

  always_comb begin
    slot_vld = '0;
    pop      = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_vld[i] = fetch_req & ~pc_adel & ((off_ext + 32'(i)) < 32'(FETCH_WIDTH));
      pop         = pop + CW'(slot_vld[i]);
    end
  end

  // Clamp the consumed count to what was actually fetched.
  assign adv = (accept_cnt_i > pop) ? pop : accept_cnt_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!en_i || stall_i) state_d = HOLD;
      HOLD:    if (en_i && !stall_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    redirect_d    = 1'b0;
    pend_vld_d    = pend_vld_q;
    pend_is_exc_d = pend_is_exc_q;
    pend_addr_d   = pend_addr_q;
    if (go) begin
      // Any redirect taken now supersedes whatever was parked.
      if (exc_valid_i) begin
        pc_d       = exc_addr_i;
        redirect_d = 1'b1;
        pend_vld_d = 1'b0;
      end else if (br_valid_i) begin
        pc_d       = br_addr_i;
        redirect_d = 1'b1;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        pc_d       = pend_addr_q;
        redirect_d = 1'b1;
        pend_vld_d = 1'b0;
      end else if (!queue_full_i) begin
        pc_d = pc_q + (32'(adv) << 2);
      end
    end else begin
      // Frozen: park the redirect. A parked exception outranks any branch.
      if (exc_valid_i) begin
        pend_vld_d    = 1'b1;
        pend_is_exc_d = 1'b1;
        pend_addr_d   = exc_addr_i;
      end else if (br_valid_i && !(pend_vld_q && pend_is_exc_q)) begin
        pend_vld_d    = 1'b1;
        pend_is_exc_d = 1'b0;
        pend_addr_d   = br_addr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      redirect_q    <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_is_exc_q <= 1'b0;
      pend_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_q    <= redirect_d;
      pend_vld_q    <= pend_vld_d;
      pend_is_exc_q <= pend_is_exc_d;
      pend_addr_q   <= pend_addr_d;
    end
  end

  assign pc_o         = pc_q;
  assign slot_valid_o = slot_vld;
  assign fetch_req_o  = fetch_req;
  assign redirect_o   = redirect_q;
  assign pc_adel_o    = pc_adel;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pc_gen_multi.sv
module tb_pc_gen_multi;

  localparam int FW = 2;
  localparam int CW = $clog2(FW + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          en, stall, queue_full;
  logic [CW-1:0] accept_cnt;
  logic          exc_valid, br_valid;
  logic [31:0]   exc_addr, br_addr;
  logic [31:0]   pc;
  logic [FW-1:0] slot_valid;
  logic          fetch_req, redirect, pc_adel;
  logic [1:0]    state;

  pc_gen_multi #(.FETCH_WIDTH(FW), .RESET_VEC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .en_i         (en),
    .stall_i      (stall),
    .queue_full_i (queue_full),
    .accept_cnt_i (accept_cnt),
    .exc_valid_i  (exc_valid),
    .exc_addr_i   (exc_addr),
    .br_valid_i   (br_valid),
    .br_addr_i    (br_addr),
    .pc_o         (pc),
    .slot_valid_o (slot_valid),
    .fetch_req_o  (fetch_req),
    .redirect_o   (redirect),
    .pc_adel_o    (pc_adel),
    .state_o      (state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [1:0] e_slot,
                         input logic e_fetch, input logic e_red, input logic e_adel,
                         input logic [1:0] e_state);
    logic [31:0] exp_pc;
    exp_q.push_back(e_pc);
    exp_pc = exp_q.pop_front();
    chk({tag, " pc"},       pc,                 exp_pc);
    chk({tag, " slot"},     32'(slot_valid),    32'(e_slot));
    chk({tag, " fetch"},    32'(fetch_req),     32'(e_fetch));
    chk({tag, " redirect"}, 32'(redirect),      32'(e_red));
    chk({tag, " adel"},     32'(pc_adel),       32'(e_adel));
    chk({tag, " state"},    32'(state),         32'(e_state));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          en, stall, qf;
    logic [CW-1:0] acc;
    logic          exc_v;
    logic [31:0]   exc_a;
    logic          br_v;
    logic [31:0]   br_a;
    logic [31:0]   e_pc;
    logic [1:0]    e_slot;
    logic          e_red, e_adel;
    logic [1:0]    e_state;
  } vec_t;

  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2;

  function automatic vec_t mk(input logic e, input logic s, input logic q, input logic [CW-1:0] a,
                              input logic xv, input logic [31:0] xa,
                              input logic bv, input logic [31:0] ba,
                              input logic [31:0] ep, input logic [1:0] es,
                              input logic er, input logic ead, input logic [1:0] est);
    vec_t v;
    v.en = e; v.stall = s; v.qf = q; v.acc = a;
    v.exc_v = xv; v.exc_a = xa; v.br_v = bv; v.br_a = ba;
    v.e_pc = ep; v.e_slot = es; v.e_red = er; v.e_adel = ead; v.e_state = est;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic e, input logic s, input logic q, input logic [CW-1:0] a,
                       input logic xv, input logic [31:0] xa, input logic bv, input logic [31:0] ba);
    en = e; stall = s; queue_full = q; accept_cnt = a;
    exc_valid = xv; exc_addr = xa; br_valid = bv; br_addr = ba;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[28];

  initial begin
    // en stall qf acc | exc_v exc_a | br_v br_a | exp pc, slot, redirect, adel, state
    vecs[0]  = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0000,2'b11,0,0,S_RUN);  // BOOT->RUN, no advance
    vecs[1]  = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0008,2'b11,0,0,S_RUN);
    vecs[2]  = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0010,2'b11,0,0,S_RUN);
    vecs[3]  = mk(1,0,0,1, 0,32'h0,        0,32'h0,        32'hBFC0_0014,2'b01,0,0,S_RUN);  // odd slot
    vecs[4]  = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0018,2'b11,0,0,S_RUN);  // accept clamped to 1
    vecs[5]  = mk(1,0,0,0, 0,32'h0,        0,32'h0,        32'hBFC0_0018,2'b11,0,0,S_RUN);
    vecs[6]  = mk(1,0,1,2, 0,32'h0,        0,32'h0,        32'hBFC0_0018,2'b11,0,0,S_RUN);  // queue full holds
    vecs[7]  = mk(0,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0018,2'b11,0,0,S_HOLD); // en low
    vecs[8]  = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0020,2'b11,0,0,S_RUN);
    vecs[9]  = mk(1,1,0,2, 0,32'h0,        1,32'h8000_1000,32'hBFC0_0020,2'b11,0,0,S_HOLD); // park branch
    vecs[10] = mk(1,1,0,2, 1,32'hBFC0_0380,0,32'h0,        32'hBFC0_0020,2'b11,0,0,S_HOLD); // exc overwrites
    vecs[11] = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0380,2'b11,1,0,S_RUN);
    vecs[12] = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'hBFC0_0388,2'b11,0,0,S_RUN);
    vecs[13] = mk(1,1,0,2, 1,32'hBFC0_0380,0,32'h0,        32'hBFC0_0388,2'b11,0,0,S_HOLD); // park exc
    vecs[14] = mk(1,1,0,2, 0,32'h0,        1,32'h8000_2000,32'hBFC0_0388,2'b11,0,0,S_HOLD); // branch dropped
    vecs[15] = mk(1,0,0,0, 0,32'h0,        0,32'h0,        32'hBFC0_0380,2'b11,1,0,S_RUN);
    vecs[16] = mk(1,0,0,0, 0,32'h0,        0,32'h0,        32'hBFC0_0380,2'b11,0,0,S_RUN);  // nothing left pending
    vecs[17] = mk(1,0,1,2, 1,32'h0000_1000,1,32'h8000_3000,32'h0000_1000,2'b11,1,0,S_RUN);  // exc beats br, qf ignored
    vecs[18] = mk(1,0,1,2, 0,32'h0,        0,32'h0,        32'h0000_1000,2'b11,0,0,S_RUN);
    vecs[19] = mk(1,0,0,2, 0,32'h0,        1,32'h8000_0002,32'h8000_0002,2'b00,1,1,S_RUN);  // misaligned
    vecs[20] = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'h8000_0002,2'b00,0,1,S_RUN);  // holds
    vecs[21] = mk(1,0,0,2, 0,32'h0,        1,32'hFFFF_FFF8,32'hFFFF_FFF8,2'b11,1,0,S_RUN);
    vecs[22] = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'h0000_0000,2'b11,0,0,S_RUN);  // wrap
    vecs[23] = mk(0,0,0,2, 0,32'h0,        1,32'h8000_4000,32'h0000_0000,2'b11,0,0,S_HOLD);
    vecs[24] = mk(1,0,0,2, 0,32'h0,        0,32'h0,        32'h8000_4000,2'b11,1,0,S_RUN);
    vecs[25] = mk(1,1,0,2, 0,32'h0,        1,32'h8000_5000,32'h8000_4000,2'b11,0,0,S_HOLD);
    vecs[26] = mk(1,1,0,2, 0,32'h0,        1,32'h8000_6000,32'h8000_4000,2'b11,0,0,S_HOLD); // br replaces br
    vecs[27] = mk(1,0,0,0, 0,32'h0,        0,32'h0,        32'h8000_6000,2'b11,1,0,S_RUN);

    resetn = 1'b0;
    en = 0; stall = 0; queue_full = 0; accept_cnt = '0;
    exc_valid = 0; exc_addr = '0; br_valid = 0; br_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 32'hBFC0_0000, 2'b00, 0, 0, 0, S_BOOT);

    resetn = 1'b1;
    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].en, vecs[i].stall, vecs[i].qf, vecs[i].acc,
            vecs[i].exc_v, vecs[i].exc_a, vecs[i].br_v, vecs[i].br_a);
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_slot, 1'b1,
              vecs[i].e_red, vecs[i].e_adel, vecs[i].e_state);
    end

    // Reset while a branch is parked: the entry must not survive.
    drive(1, 1, 0, 0, 0, 32'h0, 1, 32'h8000_7000);
    chk_all("park", 32'h8000_6000, 2'b11, 1, 0, 0, S_HOLD);
    resetn = 1'b0;
    drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    chk_all("rst2", 32'hBFC0_0000, 2'b00, 0, 0, 0, S_BOOT);
    resetn = 1'b1;
    drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    chk_all("boot2", 32'hBFC0_0000, 2'b11, 1, 0, 0, S_RUN);
    drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    chk_all("nopend", 32'hBFC0_0000, 2'b11, 1, 0, 0, S_RUN);
    drive(1, 0, 0, 2, 0, 32'h0, 0, 32'h0);
    chk_all("adv2", 32'hBFC0_0008, 2'b11, 1, 0, 0, S_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
